// File: rtl/sram_pkg.sv
// Shared types for the SRAM array controller: FSM state encoding.
package sram_pkg;

    localparam logic [1:0] StIdleEnc      = 2'd0;
    localparam logic [1:0] StPrechargeEnc = 2'd1;
    localparam logic [1:0] StAccessEnc    = 2'd2;
    localparam logic [1:0] StDoneEnc      = 2'd3;

    typedef enum logic [1:0] {
        StIdle      = StIdleEnc,
        StPrecharge = StPrechargeEnc,
        StAccess    = StAccessEnc,
        StDone      = StDoneEnc
    } sram_state_e;

endpackage

// File: rtl/sram_row_decoder.sv
// One-hot wordline decoder; all lines low when disabled or the address is past DEPTH.
module sram_row_decoder #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    addr,
    input  logic             en,
    output logic [DEPTH-1:0] wl
);

    // Comparing against every row index leaves out-of-range addresses with no match.
    always_comb begin
        wl = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wl[i] = en && (addr == i[AW-1:0]);
        end
    end

endmodule

// File: rtl/sram_array_ctrl.sv
// Four-phase SRAM array controller: precharge, wordline access, then a one-cycle done/response.
module sram_array_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] wmask,
    output logic             ready,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic [DEPTH-1:0] wl
);

    localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

    sram_state_e state_q, state_d;

    logic [AW-1:0]    addr_q;
    logic             we_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] wmask_q;

    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic in_range;
    logic wr_en;

    assign in_range = ({1'b0, addr_q} < DepthW);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (req) state_d = StPrecharge;
            StPrecharge: state_d = StAccess;
            StAccess:    state_d = StDone;
            StDone:      state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        wr_en    = 1'b0;
        if (state_q == StAccess) begin
            err_d = !in_range;
            if (we_q) begin
                wr_en = in_range;
            end else begin
                rvalid_d = 1'b1;
                rdata_d  = in_range ? mem[addr_q] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            if (state_q == StIdle && req) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
                wmask_q <= wmask;
            end
        end
    end

    // Array has no reset; a reset landing on the ACCESS cycle suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[addr_q] <= (mem[addr_q] & ~wmask_q) | (wdata_q & wmask_q);
        end
    end

    sram_row_decoder #(
        .DEPTH(DEPTH)
    ) u_row_decoder (
        .addr(addr_q),
        .en  (state_q == StAccess),
        .wl  (wl)
    );

    assign ready  = (state_q == StIdle);
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Randomized bench for sram_array_ctrl with a cycle-timeline scoreboard and array model.
module tb_sram_array_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned AW    = 4;

    logic             clk;
    logic             rst;
    logic             req;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] wmask;
    logic             ready;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             err;
    logic [DEPTH-1:0] wl;

    sram_array_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .wmask (wmask),
        .ready (ready),
        .rvalid(rvalid),
        .rdata (rdata),
        .err   (err),
        .wl    (wl)
    );

    // Expected outputs for one specific cycle; cycles with no entry expect an idle controller.
    typedef struct {
        int               cyc;
        logic             rdy;
        logic [DEPTH-1:0] wl;
        logic             rv;
        logic             er;
        logic             set_rd;
        logic [WIDTH-1:0] rd;
    } ev_t;

    ev_t tl[$];

    int vecs = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [WIDTH-1:0] model [DEPTH];
    int               free_cyc = 0;
    bit               pend = 1'b0;
    int               pend_cyc = 0;
    int               pend_a = 0;
    logic [WIDTH-1:0] pend_d = '0;
    logic [WIDTH-1:0] pend_m = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        vecs++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, want);
        end
    endtask

    function automatic ev_t mk_ev(input int c, input logic rdy_v);
        ev_t e;
        e.cyc = c;
        e.rdy = rdy_v;
        e.wl = '0;
        e.rv = 1'b0;
        e.er = 1'b0;
        e.set_rd = 1'b0;
        e.rd = '0;
        return e;
    endfunction

    // Applies one cycle of inputs and advances the reference model for that cycle.
    task automatic drive(input logic r, input logic q, input logic w, input logic [AW-1:0] a,
                         input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
        ev_t e;
        bit  oor;
        rst = r; req = q; we = w; addr = a; wdata = d; wmask = m;
        if (r) begin
            while (tl.size() > 0 && tl[$].cyc > cyc) void'(tl.pop_back());
            pend = 1'b0;
            free_cyc = cyc + 1;
            e = mk_ev(cyc + 1, 1'b1);
            e.set_rd = 1'b1;
            tl.push_back(e);
        end else begin
            if (pend && pend_cyc == cyc) begin
                model[pend_a] = (model[pend_a] & ~pend_m) | (pend_d & pend_m);
                pend = 1'b0;
            end
            if (q && cyc >= free_cyc) begin
                oor = (int'(a) >= DEPTH);
                free_cyc = cyc + 4;
                tl.push_back(mk_ev(cyc + 1, 1'b0));
                e = mk_ev(cyc + 2, 1'b0);
                if (!oor) e.wl = DEPTH'(1) << a;
                tl.push_back(e);
                e = mk_ev(cyc + 3, 1'b0);
                e.er = oor;
                if (!w) begin
                    e.rv = 1'b1;
                    e.set_rd = 1'b1;
                    e.rd = oor ? '0 : model[a];
                end
                tl.push_back(e);
                if (w && !oor) begin
                    pend = 1'b1;
                    pend_cyc = cyc + 2;
                    pend_a = int'(a);
                    pend_d = d;
                    pend_m = m;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] m);
        drive(1'b0, 1'b1, w, a, d, m);
        idle(3);
    endtask

    initial begin : monitor
        ev_t              e;
        logic [WIDTH-1:0] exp_rdata;
        exp_rdata = '0;
        forever begin
            @(negedge clk);
            while (tl.size() > 0 && tl[0].cyc < cyc) void'(tl.pop_front());
            if (mon_en) begin
                if (tl.size() > 0 && tl[0].cyc == cyc) e = tl.pop_front();
                else e = mk_ev(cyc, 1'b1);
                if (e.set_rd) exp_rdata = e.rd;
                chk("ready", 64'(ready), 64'(e.rdy));
                chk("wl", 64'(wl), 64'(e.wl));
                chk("rvalid", 64'(rvalid), 64'(e.rv));
                chk("err", 64'(err), 64'(e.er));
                chk("rdata", 64'(rdata), 64'(exp_rdata));
            end
        end
    end

    initial begin : stimulus
        logic             r_r;
        logic             q_r;
        logic             w_r;
        logic [AW-1:0]    a_r;
        logic [WIDTH-1:0] d_r;
        logic [WIDTH-1:0] m_r;
        drive(1'b1, 1'b1, 1'b1, 4'd1, 8'h55, 8'hFF);
        mon_en = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd2, 8'h00, 8'h00);
        idle(2);

        // Give every word a defined value first.
        for (int i = 0; i < DEPTH; i++) xfer(1'b1, AW'(i), 8'($urandom), 8'hFF);

        xfer(1'b1, 4'd3, 8'hA5, 8'hFF);
        xfer(1'b0, 4'd3, 8'h00, 8'h00);

        xfer(1'b1, 4'd5, 8'hFF, 8'hFF);
        xfer(1'b1, 4'd5, 8'h00, 8'h0F);
        xfer(1'b0, 4'd5, 8'h00, 8'h00);

        xfer(1'b0, 4'd13, 8'h00, 8'h00);
        xfer(1'b1, 4'd14, 8'h77, 8'hFF);

        // Write to row 7 with a stray read request arriving mid-access.
        drive(1'b0, 1'b1, 1'b1, 4'd7, 8'h99, 8'hFF);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        xfer(1'b0, 4'd7, 8'h00, 8'h00);

        xfer(1'b1, 4'd9, 8'h5A, 8'h00);
        xfer(1'b0, 4'd9, 8'h00, 8'h00);

        // Reset on the ACCESS cycle of the second write must drop it.
        xfer(1'b1, 4'd2, 8'h3C, 8'hFF);
        drive(1'b0, 1'b1, 1'b1, 4'd2, 8'h11, 8'hFF);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 4'd2, 8'h22, 8'hFF);
        xfer(1'b0, 4'd2, 8'h00, 8'h00);

        for (int i = 0; i < 600; i++) begin
            r_r = ($urandom_range(0, 39) == 0);
            q_r = 1'($urandom);
            w_r = 1'($urandom);
            a_r = AW'($urandom_range(0, 15));
            d_r = 8'($urandom);
            m_r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            drive(r_r, q_r, w_r, a_r, d_r, m_r);
        end

        idle(6);
        chk("drain", 64'(tl.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
